// File: rtl/trig_mode_pkg.sv
// Shared encodings for the trigger-mode sequencer: mode select values and FSM states.
package trig_mode_pkg;

    localparam logic [1:0] MODE_NORMAL   = 2'b00;
    localparam logic [1:0] MODE_MANUAL   = 2'b01;
    localparam logic [1:0] MODE_INFINITE = 2'b10;
    localparam logic [1:0] MODE_BURST    = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DELAY = 2'b01,
        TRIG  = 2'b10,
        RUN   = 2'b11
    } state_t;

endpackage

// File: rtl/trig_delay_counter.sv
// Loadable down-counter with a zero flag; used for the pre-trigger delay and the trigger pulse timer.
module trig_delay_counter #(
    parameter int DLY_W = 34
) (
    input  logic             gclk,
    input  logic             rst,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [DLY_W-1:0] cnt_q;

    // Decrement stops at zero so a stray dec never wraps the count.
    always_ff @(posedge gclk) begin
        if (rst)
            cnt_q <= '0;
        else if (load)
            cnt_q <= load_val;
        else if (dec && !zero)
            cnt_q <= cnt_q - DLY_W'(1);
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/trig_mode_sequencer.sv
// Trigger-mode sequencer: NORMAL pass-through, MANUAL, INFINITE and BURST shots with pre-trigger delay.
// Optional TRIG_ABORT_EN adds Abort_In, which forces IDLE from any active state.
module trig_mode_sequencer
    import trig_mode_pkg::*;
#(
    parameter int DLY_W  = 34,
    parameter int CNT_W  = 16,
    parameter int TRIG_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [1:0]       Mode_Sel,
    input  logic             Normal_Sig_In,
    input  logic             PSWR_In,
    input  logic             End_Sig_In,
`ifdef TRIG_ABORT_EN
    input  logic             Abort_In,
`endif
    input  logic [DLY_W-1:0] Delay_Vin,
    input  logic [CNT_W-1:0] Burst_Cnt_In,
    output logic             Ctrl_Sig_Out,
    output logic             Trig_Sig_Out,
    output logic             Busy_Out,
    output logic [CNT_W-1:0] Shot_Cnt_Out
);

    localparam int              TW_W    = (TRIG_W > 1) ? $clog2(TRIG_W) : 1;
    localparam logic [TW_W-1:0] TW_LOAD = TW_W'(TRIG_W - 1);

    state_t           state_q, state_d;
    logic [1:0]       mode_q;
    logic             pswr_q;
    logic             ctrl_q, ctrl_d;
    logic [CNT_W-1:0] shot_q, shot_d;
    logic             end_lat_q, end_lat_d;
    logic             dly_load, dly_dec, dly_zero;
    logic             tw_load, tw_dec, tw_zero;
    logic             pswr_rise;
    logic             abort;
    logic             rearm;
    logic [CNT_W-1:0] burst_tgt;

`ifdef TRIG_ABORT_EN
    assign abort = Abort_In;
`else
    assign abort = 1'b0;
`endif

    assign pswr_rise = PSWR_In & ~pswr_q;
    assign burst_tgt = (Burst_Cnt_In == '0) ? CNT_W'(1) : Burst_Cnt_In;

    trig_delay_counter #(.DLY_W(DLY_W)) u_dly (
        .gclk     (Clock),
        .rst      (Reset),
        .load     (dly_load),
        .load_val (Delay_Vin),
        .dec      (dly_dec),
        .zero     (dly_zero)
    );

    // Pulse timer is loaded with TRIG_W-1 so TRIG spans exactly TRIG_W cycles.
    trig_delay_counter #(.DLY_W(TW_W)) u_tw (
        .gclk     (Clock),
        .rst      (Reset),
        .load     (tw_load),
        .load_val (TW_LOAD),
        .dec      (tw_dec),
        .zero     (tw_zero)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            mode_q    <= MODE_NORMAL;
            pswr_q    <= 1'b0;
            ctrl_q    <= 1'b0;
            shot_q    <= '0;
            end_lat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pswr_q    <= PSWR_In;
            ctrl_q    <= ctrl_d;
            shot_q    <= shot_d;
            end_lat_q <= end_lat_d;
            if (state_q == IDLE)
                mode_q <= Mode_Sel;
        end
    end

    always_comb begin
        state_d   = state_q;
        ctrl_d    = 1'b0;
        shot_d    = shot_q;
        end_lat_d = end_lat_q;
        dly_load  = 1'b0;
        dly_dec   = 1'b0;
        tw_load   = 1'b0;
        tw_dec    = 1'b0;
        rearm     = 1'b0;

        case (state_q)
            IDLE: begin
                // Live Mode_Sel here so a mode change on the start edge takes effect.
                if (Mode_Sel == MODE_NORMAL) begin
                    ctrl_d = Normal_Sig_In;
                end else if (pswr_rise) begin
                    state_d  = DELAY;
                    dly_load = 1'b1;
                    shot_d   = '0;
                end
            end
            DELAY: begin
                if (dly_zero) begin
                    state_d   = TRIG;
                    ctrl_d    = 1'b1;
                    tw_load   = 1'b1;
                    end_lat_d = 1'b0;
                    if (shot_q != '1)
                        shot_d = shot_q + CNT_W'(1);
                end else begin
                    dly_dec = 1'b1;
                end
            end
            TRIG: begin
                ctrl_d    = 1'b1;
                end_lat_d = end_lat_q | End_Sig_In;
                if (tw_zero)
                    state_d = RUN;
                else
                    tw_dec = 1'b1;
            end
            RUN: begin
                ctrl_d = 1'b1;
                if (End_Sig_In || end_lat_q) begin
                    ctrl_d  = 1'b0;
                    state_d = IDLE;
                    if (mode_q == MODE_INFINITE)
                        rearm = (Mode_Sel == MODE_INFINITE);
                    else if (mode_q == MODE_BURST)
                        rearm = (shot_q < burst_tgt);
                    if (rearm) begin
                        state_d  = DELAY;
                        dly_load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            ctrl_d   = 1'b0;
            shot_d   = shot_q;
            dly_load = 1'b0;
            tw_load  = 1'b0;
        end
    end

    assign Ctrl_Sig_Out = ctrl_q;
    assign Trig_Sig_Out = (state_q == TRIG);
    assign Busy_Out     = (state_q != IDLE);
    assign Shot_Cnt_Out = shot_q;

endmodule

// File: tb/tb_trig_mode_sequencer.sv
// Directed bench for trig_mode_sequencer; define TRIG_ABORT_EN to also exercise Abort_In.
module tb_trig_mode_sequencer;

    localparam int DLY_W  = 34;
    localparam int CNT_W  = 16;
    localparam int TRIG_W = 4;

    logic             Clock = 1'b0;
    logic             Reset = 1'b0;
    logic [1:0]       Mode_Sel = 2'b00;
    logic             Normal_Sig_In = 1'b0;
    logic             PSWR_In = 1'b0;
    logic             End_Sig_In = 1'b0;
    logic             Abort_In = 1'b0;
    logic [DLY_W-1:0] Delay_Vin = '0;
    logic [CNT_W-1:0] Burst_Cnt_In = '0;
    logic             Ctrl_Sig_Out;
    logic             Trig_Sig_Out;
    logic             Busy_Out;
    logic [CNT_W-1:0] Shot_Cnt_Out;

    int tests = 0;
    int fails = 0;

    trig_mode_sequencer #(.DLY_W(DLY_W), .CNT_W(CNT_W), .TRIG_W(TRIG_W)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Mode_Sel      (Mode_Sel),
        .Normal_Sig_In (Normal_Sig_In),
        .PSWR_In       (PSWR_In),
        .End_Sig_In    (End_Sig_In),
`ifdef TRIG_ABORT_EN
        .Abort_In      (Abort_In),
`endif
        .Delay_Vin     (Delay_Vin),
        .Burst_Cnt_In  (Burst_Cnt_In),
        .Ctrl_Sig_Out  (Ctrl_Sig_Out),
        .Trig_Sig_Out  (Trig_Sig_Out),
        .Busy_Out      (Busy_Out),
        .Shot_Cnt_Out  (Shot_Cnt_Out)
    );

    always #5 Clock = ~Clock;

    // Returns 1 time unit after a rising edge: outputs settled, inputs safe to change.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Mode_Sel = 2'b11; Normal_Sig_In = 1'b1; Delay_Vin = 34'd9;
        tick(); tick();
        tests++; if (Ctrl_Sig_Out !== 1'b0) begin fails++; $display("FAIL reset ctrl got %b want 0", Ctrl_Sig_Out); end
        tests++; if (Trig_Sig_Out !== 1'b0) begin fails++; $display("FAIL reset trig got %b want 0", Trig_Sig_Out); end
        tests++; if (Busy_Out !== 1'b0) begin fails++; $display("FAIL reset busy got %b want 0", Busy_Out); end
        tests++; if (Shot_Cnt_Out !== 16'd0) begin fails++; $display("FAIL reset shot got %0d want 0", Shot_Cnt_Out); end
        Reset = 1'b0; Mode_Sel = 2'b00; Normal_Sig_In = 1'b0;
        tick();
    endtask

    // Mode switch to MANUAL on the same edge as the PSWR rise; delay 5, end 10 cycles after trigger.
    task automatic test_manual();
        logic et, ec, eb;
        Delay_Vin = 34'd5; Mode_Sel = 2'b01; PSWR_In = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            et = (c >= 7 && c <= 10);
            ec = (c >= 7 && c <= 17);
            eb = (c >= 1 && c <= 17);
            tests++; if (Trig_Sig_Out !== et) begin fails++; $display("FAIL manual trig c=%0d got %b want %b", c, Trig_Sig_Out, et); end
            tests++; if (Ctrl_Sig_Out !== ec) begin fails++; $display("FAIL manual ctrl c=%0d got %b want %b", c, Ctrl_Sig_Out, ec); end
            tests++; if (Busy_Out !== eb) begin fails++; $display("FAIL manual busy c=%0d got %b want %b", c, Busy_Out, eb); end
            if (c >= 7) begin
                tests++; if (Shot_Cnt_Out !== 16'd1) begin fails++; $display("FAIL manual shot c=%0d got %0d want 1", c, Shot_Cnt_Out); end
            end
            PSWR_In    = (c == 12);          // rise during RUN must be ignored
            End_Sig_In = (c == 17);
            if (c == 2) Delay_Vin = 34'd0;   // ignored while counting down
        end
    endtask

    task automatic test_normal();
        logic [7:0] pat;
        pat = 8'b1011_0010;
        Mode_Sel = 2'b00;
        for (int i = 0; i < 8; i++) begin
            Normal_Sig_In = pat[i];
            PSWR_In = (i == 2 || i == 5);
            tick();
            tests++; if (Ctrl_Sig_Out !== pat[i]) begin fails++; $display("FAIL normal ctrl i=%0d got %b want %b", i, Ctrl_Sig_Out, pat[i]); end
            tests++; if (Trig_Sig_Out !== 1'b0) begin fails++; $display("FAIL normal trig i=%0d got %b want 0", i, Trig_Sig_Out); end
            tests++; if (Busy_Out !== 1'b0) begin fails++; $display("FAIL normal busy i=%0d got %b want 0", i, Busy_Out); end
        end
        PSWR_In = 1'b0; Normal_Sig_In = 1'b0;
        tick();
    endtask

    // End only pulses on the first TRIG cycle of each shot, so each RUN exit relies on the latch.
    task automatic test_burst();
        logic et, ec, eb;
        logic [CNT_W-1:0] es;
        int ph;
        Mode_Sel = 2'b11; Burst_Cnt_In = 16'd3; Delay_Vin = 34'd0;
        tick();
        PSWR_In = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            ph = (c - 1) % 6;
            et = (c <= 18) && (ph >= 1) && (ph <= 4);
            ec = (c <= 18) && (ph >= 1);
            eb = (c <= 18);
            es = (c < 2) ? 16'd0 : (c < 8) ? 16'd1 : (c < 14) ? 16'd2 : 16'd3;
            tests++; if (Trig_Sig_Out !== et) begin fails++; $display("FAIL burst3 trig c=%0d got %b want %b", c, Trig_Sig_Out, et); end
            tests++; if (Ctrl_Sig_Out !== ec) begin fails++; $display("FAIL burst3 ctrl c=%0d got %b want %b", c, Ctrl_Sig_Out, ec); end
            tests++; if (Busy_Out !== eb) begin fails++; $display("FAIL burst3 busy c=%0d got %b want %b", c, Busy_Out, eb); end
            tests++; if (Shot_Cnt_Out !== es) begin fails++; $display("FAIL burst3 shot c=%0d got %0d want %0d", c, Shot_Cnt_Out, es); end
            PSWR_In    = 1'b0;
            End_Sig_In = (c <= 18) && (ph == 1);
        end
        Burst_Cnt_In = 16'd0;
        PSWR_In = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            et = (c >= 2 && c <= 5);
            eb = (c <= 6);
            es = (c < 2) ? 16'd0 : 16'd1;
            tests++; if (Trig_Sig_Out !== et) begin fails++; $display("FAIL burst0 trig c=%0d got %b want %b", c, Trig_Sig_Out, et); end
            tests++; if (Busy_Out !== eb) begin fails++; $display("FAIL burst0 busy c=%0d got %b want %b", c, Busy_Out, eb); end
            tests++; if (Shot_Cnt_Out !== es) begin fails++; $display("FAIL burst0 shot c=%0d got %0d want %0d", c, Shot_Cnt_Out, es); end
            PSWR_In    = 1'b0;
            End_Sig_In = (c == 2);
        end
        End_Sig_In = 1'b0;
    endtask

    // Period 9: DELAY 3, TRIG 4, RUN 2. Mode_Sel -> 01 in shot 4's RUN stops after that shot.
    task automatic test_infinite();
        logic et, ec, eb;
        logic [CNT_W-1:0] es;
        int ph, k;
        Mode_Sel = 2'b10; Delay_Vin = 34'd2; Burst_Cnt_In = 16'd0;
        PSWR_In = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            k  = (c - 1) / 9;
            ph = (c - 1) % 9 + 1;
            if (c <= 36) begin
                et = (ph >= 4 && ph <= 7);
                ec = (ph >= 4);
                eb = 1'b1;
                es = CNT_W'((ph >= 4) ? k + 1 : k);
            end else begin
                et = 1'b0; ec = 1'b0; eb = 1'b0; es = 16'd4;
            end
            tests++; if (Trig_Sig_Out !== et) begin fails++; $display("FAIL inf trig c=%0d got %b want %b", c, Trig_Sig_Out, et); end
            tests++; if (Ctrl_Sig_Out !== ec) begin fails++; $display("FAIL inf ctrl c=%0d got %b want %b", c, Ctrl_Sig_Out, ec); end
            tests++; if (Busy_Out !== eb) begin fails++; $display("FAIL inf busy c=%0d got %b want %b", c, Busy_Out, eb); end
            tests++; if (Shot_Cnt_Out !== es) begin fails++; $display("FAIL inf shot c=%0d got %0d want %0d", c, Shot_Cnt_Out, es); end
            PSWR_In    = 1'b0;
            End_Sig_In = (c <= 36) && (ph == 9);
            if (c == 10) Mode_Sel = 2'b11;   // during DELAY: must not reach the mode register
            if (c == 13) Mode_Sel = 2'b10;
            if (c == 35) Mode_Sel = 2'b01;
        end
        End_Sig_In = 1'b0;
    endtask

    task automatic test_reset_mid();
        Mode_Sel = 2'b01; Delay_Vin = 34'd5; PSWR_In = 1'b1;
        tick(); PSWR_In = 1'b0;
        tick(); tick();
        tests++; if (Busy_Out !== 1'b1) begin fails++; $display("FAIL rstdly busy before got %b want 1", Busy_Out); end
        Reset = 1'b1;
        tick();
        tests++; if (Busy_Out !== 1'b0) begin fails++; $display("FAIL rstdly busy got %b want 0", Busy_Out); end
        tests++; if (Ctrl_Sig_Out !== 1'b0) begin fails++; $display("FAIL rstdly ctrl got %b want 0", Ctrl_Sig_Out); end
        Reset = 1'b0; Delay_Vin = 34'd0; PSWR_In = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            PSWR_In = 1'b0;
            if (c == 2) begin
                tests++; if (Trig_Sig_Out !== 1'b1) begin fails++; $display("FAIL rstrun trig c=2 got %b want 1", Trig_Sig_Out); end
            end
            if (c == 7) begin
                tests++; if (Ctrl_Sig_Out !== 1'b1) begin fails++; $display("FAIL rstrun ctrl in RUN got %b want 1", Ctrl_Sig_Out); end
                Reset = 1'b1;
            end
            if (c == 8) begin
                tests++; if (Ctrl_Sig_Out !== 1'b0) begin fails++; $display("FAIL rstrun ctrl got %b want 0", Ctrl_Sig_Out); end
                tests++; if (Busy_Out !== 1'b0) begin fails++; $display("FAIL rstrun busy got %b want 0", Busy_Out); end
                tests++; if (Shot_Cnt_Out !== 16'd0) begin fails++; $display("FAIL rstrun shot got %0d want 0", Shot_Cnt_Out); end
                Reset = 1'b0;
            end
        end
        PSWR_In = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            PSWR_In = 1'b0;
            if (c == 2) begin
                tests++; if (Trig_Sig_Out !== 1'b1) begin fails++; $display("FAIL restart trig got %b want 1", Trig_Sig_Out); end
                tests++; if (Shot_Cnt_Out !== 16'd1) begin fails++; $display("FAIL restart shot got %0d want 1", Shot_Cnt_Out); end
                End_Sig_In = 1'b1;
            end
            if (c == 7) begin
                tests++; if (Busy_Out !== 1'b0) begin fails++; $display("FAIL restart busy got %b want 0", Busy_Out); end
                End_Sig_In = 1'b0;
            end
        end
    endtask

`ifdef TRIG_ABORT_EN
    task automatic test_abort();
        Mode_Sel = 2'b01; Delay_Vin = 34'd0; PSWR_In = 1'b1;
        tick(); PSWR_In = 1'b0;
        tick();
        tests++; if (Trig_Sig_Out !== 1'b1) begin fails++; $display("FAIL abort pre trig got %b want 1", Trig_Sig_Out); end
        Abort_In = 1'b1;
        tick();
        Abort_In = 1'b0;
        tests++; if (Trig_Sig_Out !== 1'b0) begin fails++; $display("FAIL abort trig got %b want 0", Trig_Sig_Out); end
        tests++; if (Ctrl_Sig_Out !== 1'b0) begin fails++; $display("FAIL abort ctrl got %b want 0", Ctrl_Sig_Out); end
        tests++; if (Busy_Out !== 1'b0) begin fails++; $display("FAIL abort busy got %b want 0", Busy_Out); end
        tests++; if (Shot_Cnt_Out !== 16'd1) begin fails++; $display("FAIL abort shot got %0d want 1", Shot_Cnt_Out); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_manual();
        test_normal();
        test_burst();
        test_infinite();
        test_reset_mid();
`ifdef TRIG_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
